ram_be_dp: RTL and testbench

Simple dual-port synchronous RAM with one write port and one read port, per-byte write enables, and a selectable read-during-write policy. A built-in clear engine fills the array with `INIT_VALUE` after every reset. Read data is returned with a `rd_valid` strobe. It serves as the general storage primitive for buffers and lookup tables in the design, where the plain single-port RAM lacks enough ports or control.

---
 rtl/ram_be_dp.sv | 147 ++++++++++++++
 tb/tb_ram_be_dp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_be_dp.sv
// Simple dual-port RAM with byte enables, selectable read-during-write policy and a post-reset clear engine.
// Optional macro RAM_OUTREG_EN adds a second read output register stage (2-cycle read latency).
module ram_be_dp #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned BE_W = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_din,
    input  logic [BE_W-1:0]       wr_be,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dout,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_mem_mask;
    logic [DATA_WIDTH-1:0] w_be_mask;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_merged;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd_fire;

    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_dout;

    // Expand lane enables into a bit mask.
    always_comb begin
        w_be_mask = '0;
        for (int unsigned i = 0; i < BE_W; i++) begin
            w_be_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be[i]}};
        end
    end

    // Clear engine owns the write port until the last address is filled.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_mem_we       = 1'b0;
        w_mem_addr     = wr_addr;
        w_mem_wdata    = wr_din;
        w_mem_mask     = w_be_mask;
        w_rd_fire      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we       = 1'b1;
                w_mem_addr     = r_clr_addr;
                w_mem_wdata    = INIT_VALUE;
                w_mem_mask     = '1;
                w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
                if (&r_clr_addr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_mem_we  = wr_req;
                w_rd_fire = rd_req;
            end
        endcase
        if (rst) begin
            w_mem_we  = 1'b0;
            w_rd_fire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= (r_mem[w_mem_addr] & ~w_mem_mask) | (w_mem_wdata & w_mem_mask);
        end
    end

    // Same-address bypass forwards the merged word when new-data policy is selected.
    assign w_rd_old    = r_mem[rd_addr];
    assign w_rd_merged = (w_rd_old & ~w_be_mask) | (wr_din & w_be_mask);
    assign w_rd_data   = ((RDW_MODE == 1) && wr_req && (wr_addr == rd_addr)) ? w_rd_merged : w_rd_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_dout  <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_dout <= w_rd_data;
            end
        end
    end

`ifdef RAM_OUTREG_EN
    logic                  r_rd_valid2;
    logic [DATA_WIDTH-1:0] r_rd_dout2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid2 <= 1'b0;
            r_rd_dout2  <= '0;
        end else begin
            r_rd_valid2 <= r_rd_valid;
            if (r_rd_valid) begin
                r_rd_dout2 <= r_rd_dout;
            end
        end
    end

    assign rd_valid = r_rd_valid2;
    assign rd_dout  = r_rd_dout2;
`else
    assign rd_valid = r_rd_valid;
    assign rd_dout  = r_rd_dout;
`endif

    assign init_busy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_be_dp.sv
// Bench for ram_be_dp: two instances (old-data/INIT 0 and new-data/INIT 0x5A5A) share stimulus and are checked against an array model.
module tb_ram_be_dp;

`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [15:0] wr_din;
    logic [1:0]  wr_be;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic [15:0] dout0, dout1;
    logic        v0, v1, busy0, busy1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_be_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(0), .INIT_VALUE(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_dout(dout0), .rd_valid(v0), .init_busy(busy0));

    ram_be_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(1), .INIT_VALUE(16'h5A5A)) dut1 (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_dout(dout1), .rd_valid(v1), .init_busy(busy1));

    // Model: array contents, busy countdown, and a LAT-deep result pipeline per instance.
    logic [15:0] mmem [2][16];
    logic [15:0] init_v [2];
    int          rdw_v [2];
    int          busy_left;
    logic        s1_v [2];
    logic [15:0] s1_d [2];
    logic        ev [2];
    logic [15:0] ed [2];
    logic [15:0] rdata, nw;
    logic        fire;

    initial begin
        init_v[0] = 16'h0000; init_v[1] = 16'h5A5A;
        rdw_v[0]  = 0;        rdw_v[1]  = 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            busy_left = 16;
            for (int k = 0; k < 2; k++) begin
                for (int a = 0; a < 16; a++) mmem[k][a] = init_v[k];
                s1_v[k] = 1'b0; s1_d[k] = '0; ev[k] = 1'b0; ed[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                fire  = (busy_left == 0) && rd_req;
                rdata = mmem[k][rd_addr];
                if (busy_left == 0 && wr_req) begin
                    nw = mmem[k][wr_addr];
                    if (wr_be[0]) nw[7:0]  = wr_din[7:0];
                    if (wr_be[1]) nw[15:8] = wr_din[15:8];
                    if (rdw_v[k] == 1 && rd_addr == wr_addr) rdata = nw;
                    mmem[k][wr_addr] = nw;
                end
                if (LAT == 2) begin
                    ev[k] = s1_v[k];
                    if (s1_v[k]) ed[k] = s1_d[k];
                    s1_v[k] = fire;
                    if (fire) s1_d[k] = rdata;
                end else begin
                    ev[k] = fire;
                    if (fire) ed[k] = rdata;
                end
            end
            if (busy_left > 0) busy_left = busy_left - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy0", 32'(busy0), 32'(busy_left != 0));
            chk("m_busy1", 32'(busy1), 32'(busy_left != 0));
            chk("m_valid0", 32'(v0), 32'(ev[0]));
            chk("m_valid1", 32'(v1), 32'(ev[1]));
            chk("m_dout0", 32'(dout0), 32'(ed[0]));
            chk("m_dout1", 32'(dout1), 32'(ed[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_len(input string nm);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (busy0 && n < 100);
        chk(nm, 32'(n), 32'd16);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_req = 1'b1; wr_addr = a; wr_din = d; wr_be = be;
        cyc();
        wr_req = 1'b0;
    endtask

    // Optional simultaneous write, then a read with literal expectations for both instances.
    task automatic rw_lit(input string nm, input logic we, input logic [3:0] wa, input logic [15:0] d,
                          input logic [1:0] be, input logic [3:0] ra, input logic [15:0] e0, input logic [15:0] e1);
        wr_req = we; wr_addr = wa; wr_din = d; wr_be = be;
        rd_req = 1'b1; rd_addr = ra;
        cyc();
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (LAT - 1) cyc();
        chk({nm, "_v0"}, 32'(v0), 32'd1);
        chk({nm, "_d0"}, 32'(dout0), 32'(e0));
        chk({nm, "_v1"}, 32'(v1), 32'd1);
        chk({nm, "_d1"}, 32'(dout1), 32'(e1));
        cyc();
        chk({nm, "_strobe"}, 32'(v0), 32'd0);
    endtask

    logic [15:0] sv [4];

    initial begin
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_din = '0; wr_be = '0; rd_req = 1'b0; rd_addr = '0;
        cyc();
        chk_en = 1'b1;
        repeat (2) cyc();
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_dout", 32'(dout1), 32'd0);
        rst = 1'b0;
        busy_len("busy_len");

        for (int a = 0; a < 16; a++) begin
            rd_req = 1'b1; rd_addr = 4'(a);
            cyc();
        end
        rd_req = 1'b0;
        repeat (LAT + 1) cyc();
        rw_lit("init_rd", 1'b0, 4'd0, 16'h0, 2'b00, 4'd4, 16'h0000, 16'h5A5A);

        wr(4'd5, 16'hA5C3, 2'b11);
        rw_lit("full_wr", 1'b0, 4'd0, 16'h0, 2'b00, 4'd5, 16'hA5C3, 16'hA5C3);
        wr(4'd5, 16'h1234, 2'b01);
        rw_lit("lane0_wr", 1'b0, 4'd0, 16'h0, 2'b00, 4'd5, 16'hA534, 16'hA534);
        wr(4'd5, 16'hFFFF, 2'b00);
        rw_lit("be0_wr", 1'b0, 4'd0, 16'h0, 2'b00, 4'd5, 16'hA534, 16'hA534);

        rw_lit("rdw_full", 1'b1, 4'd7, 16'hFFFF, 2'b11, 4'd7, 16'h0000, 16'hFFFF);
        rw_lit("rdw_hi", 1'b1, 4'd8, 16'hFFFF, 2'b10, 4'd8, 16'h0000, 16'hFF5A);
        rw_lit("after_hi", 1'b0, 4'd0, 16'h0, 2'b00, 4'd8, 16'hFF00, 16'hFF5A);
        rw_lit("diff_addr", 1'b1, 4'd3, 16'h1111, 2'b11, 4'd5, 16'hA534, 16'hA534);
        rw_lit("diff_rb", 1'b0, 4'd0, 16'h0, 2'b00, 4'd3, 16'h1111, 16'h1111);

        sv[0] = 16'h0011; sv[1] = 16'h0022; sv[2] = 16'h0033; sv[3] = 16'h0044;
        for (int i = 0; i < 4; i++) wr(4'(i), sv[i], 2'b11);
        for (int c = 1; c <= 4 + LAT; c++) begin
            rd_req = (c <= 4); rd_addr = 4'(c - 1);
            cyc();
            if (c - LAT >= 0 && c - LAT < 4) begin
                chk("stream_v", 32'(v0), 32'd1);
                chk("stream_d", 32'(dout0), 32'(sv[c - LAT]));
            end else begin
                chk("stream_idle_v", 32'(v0), 32'd0);
            end
        end
        rd_req = 1'b0;

        rd_req = 1'b1; rd_addr = 4'd0;
        cyc();
        rd_req = 1'b0; rst = 1'b1;
        cyc();
        chk("rst_cancel_v", 32'(v1), 32'd0);
        chk("rst_cancel_d", 32'(dout1), 32'd0);
        rst = 1'b0;
        repeat (3) cyc();
        wr_req = 1'b1; wr_addr = 4'd2; wr_din = 16'hBEEF; wr_be = 2'b11; rd_req = 1'b1; rd_addr = 4'd2;
        cyc();
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (LAT) cyc();
        chk("busy_drop_v", 32'(v0), 32'd0);
        repeat (4 - LAT) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        busy_len("busy_len_restart");
        rw_lit("busy_wr_drop", 1'b0, 4'd0, 16'h0, 2'b00, 4'd2, 16'h0000, 16'h5A5A);
        rw_lit("clear_old", 1'b0, 4'd0, 16'h0, 2'b00, 4'd5, 16'h0000, 16'h5A5A);

        repeat (2) cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
